// File: rtl/calc2_req_scheduler.sv
// calc2 request scheduler: per-port two-word command capture into FIFOs,
// round-robin issue to one shared ALU under an outstanding limit, response routing.
module calc2_req_scheduler #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic         c_clk,
    input  logic         reset,
    input  logic [15:0]  req_cmd_in,
    input  logic [127:0] req_data_in,
    input  logic [7:0]   req_tag_in,
    output logic         alu_valid,
    input  logic         alu_ready,
    output logic [3:0]   alu_cmd,
    output logic [31:0]  alu_op1,
    output logic [31:0]  alu_op2,
    output logic [1:0]   alu_port,
    output logic [1:0]   alu_tag,
    input  logic         alu_resp_valid,
    input  logic [1:0]   alu_resp,
    input  logic [31:0]  alu_resp_data,
    input  logic [1:0]   alu_resp_port,
    input  logic [1:0]   alu_resp_tag,
    output logic [7:0]   out_resp,
    output logic [127:0] out_data,
    output logic [7:0]   out_tag,
    output logic [3:0]   ovf
);

    localparam int unsigned NP = 4;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [4:0]  MAX_CNT  = MAX_OUTSTANDING[4:0];

    typedef enum logic {
        CAP_IDLE,
        CAP_OP2
    } cap_state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  tag;
    } entry_t;

    cap_state_t    cap_state [NP];
    cap_state_t    cap_next  [NP];
    logic [3:0]    cap_cmd   [NP];
    logic [31:0]   cap_op1   [NP];
    logic [1:0]    cap_tag   [NP];
    logic [NP-1:0] push;
    entry_t        push_entry [NP];

    entry_t        mem [NP][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr [NP];
    logic [AW-1:0] rd_ptr [NP];
    logic [AW:0]   fill   [NP];
    logic [NP-1:0] fifo_empty;
    logic [NP-1:0] fifo_full;
    logic [NP-1:0] push_ok;
    logic [NP-1:0] pop;

    logic [1:0]    rr_ptr;
    logic [1:0]    gnt_port;
    logic          found;
    logic          hs;
    logic          retire;
    logic [4:0]    projected;
    logic          can_issue;
    logic          load;
    logic [3:0]    outstanding;
    entry_t        head;

    // Capture FSM: first word latches cmd/op1/tag, second word completes the entry.
    always_comb begin
        for (int unsigned p = 0; p < NP; p++) begin
            cap_next[p]   = cap_state[p];
            push[p]       = 1'b0;
            push_entry[p] = '{cmd: cap_cmd[p], op1: cap_op1[p],
                              op2: req_data_in[32*p +: 32], tag: cap_tag[p]};
            case (cap_state[p])
                CAP_IDLE: if (req_cmd_in[4*p +: 4] != '0) cap_next[p] = CAP_OP2;
                CAP_OP2: begin
                    cap_next[p] = CAP_IDLE;
                    push[p]     = 1'b1;
                end
                default: cap_next[p] = CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned p = 0; p < NP; p++) begin
                cap_state[p] <= CAP_IDLE;
                cap_cmd[p]   <= '0;
                cap_op1[p]   <= '0;
                cap_tag[p]   <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NP; p++) begin
                cap_state[p] <= cap_next[p];
                if (cap_state[p] == CAP_IDLE && req_cmd_in[4*p +: 4] != '0) begin
                    cap_cmd[p] <= req_cmd_in[4*p +: 4];
                    cap_op1[p] <= req_data_in[32*p +: 32];
                    cap_tag[p] <= req_tag_in[2*p +: 2];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NP; p++) begin
            fifo_empty[p] = (fill[p] == '0);
            fifo_full[p]  = (fill[p] == FULL_CNT);
        end
    end

    // A pop in the same cycle frees room, so a push into a full FIFO still lands.
    always_comb push_ok = push & (~fifo_full | pop);

    always_ff @(posedge c_clk) begin
        for (int unsigned p = 0; p < NP; p++) begin
            if (push_ok[p]) mem[p][wr_ptr[p]] <= push_entry[p];
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned p = 0; p < NP; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                fill[p]   <= '0;
            end
            ovf <= '0;
        end else begin
            for (int unsigned p = 0; p < NP; p++) begin
                if (push_ok[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])     rd_ptr[p] <= rd_ptr[p] + 1'b1;
                case ({push_ok[p], pop[p]})
                    2'b10:   fill[p] <= fill[p] + 1'b1;
                    2'b01:   fill[p] <= fill[p] - 1'b1;
                    default: fill[p] <= fill[p];
                endcase
                if (push[p] && !push_ok[p]) ovf[p] <= 1'b1;
            end
        end
    end

    // Limit check uses the count as it will stand after this cycle's handshake and retire.
    always_comb begin
        hs        = alu_valid & alu_ready;
        retire    = alu_resp_valid & (outstanding != '0);
        projected = {1'b0, outstanding} + {4'b0, hs} - {4'b0, retire};
        can_issue = (!alu_valid || alu_ready) && (projected < MAX_CNT);
        found     = 1'b0;
        gnt_port  = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (!found && !fifo_empty[rr_ptr + 2'(i)]) begin
                found    = 1'b1;
                gnt_port = rr_ptr + 2'(i);
            end
        end
        load = can_issue & found;
        pop  = load ? (4'b0001 << gnt_port) : '0;
        head = mem[gnt_port][rd_ptr[gnt_port]];
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            alu_valid   <= 1'b0;
            alu_cmd     <= '0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            alu_port    <= '0;
            alu_tag     <= '0;
            rr_ptr      <= '0;
            outstanding <= '0;
        end else begin
            outstanding <= projected[3:0];
            if (load) begin
                alu_valid <= 1'b1;
                alu_cmd   <= head.cmd;
                alu_op1   <= head.op1;
                alu_op2   <= head.op2;
                alu_port  <= gnt_port;
                alu_tag   <= head.tag;
                rr_ptr    <= gnt_port + 2'd1;
            end else if (hs) begin
                alu_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            if (alu_resp_valid) begin
                out_resp[{alu_resp_port, 1'b0} +: 2] <= alu_resp;
                out_data[{alu_resp_port, 5'b0} +: 32] <= alu_resp_data;
                out_tag[{alu_resp_port, 1'b0} +: 2]  <= alu_resp_tag;
            end
        end
    end

endmodule

// File: tb/tb_calc2_req_scheduler.sv
// Directed bench for calc2_req_scheduler: one default instance and one with
// FIFO_DEPTH=2 / MAX_OUTSTANDING=2 driven from the same inputs.
module tb_calc2_req_scheduler;

    logic         c_clk = 1'b0;
    logic         reset;
    logic [15:0]  req_cmd_in;
    logic [127:0] req_data_in;
    logic [7:0]   req_tag_in;
    logic         alu_ready;
    logic         alu_resp_valid;
    logic [1:0]   alu_resp;
    logic [31:0]  alu_resp_data;
    logic [1:0]   alu_resp_port;
    logic [1:0]   alu_resp_tag;

    logic         a_valid, b_valid;
    logic [3:0]   a_cmd, b_cmd;
    logic [31:0]  a_op1, b_op1, a_op2, b_op2;
    logic [1:0]   a_port, b_port, a_tag, b_tag;
    logic [7:0]   a_out_resp, b_out_resp, a_out_tag, b_out_tag;
    logic [127:0] a_out_data, b_out_data;
    logic [3:0]   a_ovf, b_ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 c_clk = ~c_clk;

    calc2_req_scheduler u_dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .alu_valid(a_valid), .alu_ready(alu_ready), .alu_cmd(a_cmd),
        .alu_op1(a_op1), .alu_op2(a_op2), .alu_port(a_port), .alu_tag(a_tag),
        .alu_resp_valid(alu_resp_valid), .alu_resp(alu_resp), .alu_resp_data(alu_resp_data),
        .alu_resp_port(alu_resp_port), .alu_resp_tag(alu_resp_tag),
        .out_resp(a_out_resp), .out_data(a_out_data), .out_tag(a_out_tag), .ovf(a_ovf)
    );

    calc2_req_scheduler #(.FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) u_dut_small (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .alu_valid(b_valid), .alu_ready(alu_ready), .alu_cmd(b_cmd),
        .alu_op1(b_op1), .alu_op2(b_op2), .alu_port(b_port), .alu_tag(b_tag),
        .alu_resp_valid(alu_resp_valid), .alu_resp(alu_resp), .alu_resp_data(alu_resp_data),
        .alu_resp_port(alu_resp_port), .alu_resp_tag(alu_resp_tag),
        .out_resp(b_out_resp), .out_data(b_out_data), .out_tag(b_out_tag), .ovf(b_ovf)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_inputs();
        req_cmd_in     = '0;
        req_data_in    = '0;
        req_tag_in     = '0;
        alu_resp_valid = 1'b0;
        alu_resp       = '0;
        alu_resp_data  = '0;
        alu_resp_port  = '0;
        alu_resp_tag   = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        alu_ready = 1'b0;
        @(negedge c_clk);
        @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
    endtask

    // Word 1 then word 2 on every port in mask; cmd is left asserted during word 2.
    task automatic send_ports(input logic [3:0] mask, input logic [3:0] cmd,
                              input logic [31:0] op1_base, input logic [31:0] op2_base,
                              input logic [1:0] tag);
        for (int p = 0; p < 4; p++) begin
            if (mask[p]) begin
                req_cmd_in[4*p +: 4]   = cmd;
                req_data_in[32*p +: 32] = op1_base + 32'(p);
                req_tag_in[2*p +: 2]   = tag;
            end
        end
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            if (mask[p]) req_data_in[32*p +: 32] = op2_base + 32'(p);
        end
        @(negedge c_clk);
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({a_valid, a_cmd, a_op1, a_op2, a_port, a_tag} !== '0) begin
            tests_failed++;
            $display("FAIL reset_alu: got valid=%b cmd=%h op1=%h expected all 0", a_valid, a_cmd, a_op1);
        end
        tests_run++;
        if ({a_out_resp, a_out_data, a_out_tag, a_ovf} !== '0) begin
            tests_failed++;
            $display("FAIL reset_out: got resp=%h data=%h tag=%h ovf=%h expected 0", a_out_resp, a_out_data, a_out_tag, a_ovf);
        end
        tests_run++;
        if ({b_valid, b_ovf, b_out_resp} !== '0) begin
            tests_failed++;
            $display("FAIL reset_small: got valid=%b ovf=%h resp=%h expected 0", b_valid, b_ovf, b_out_resp);
        end
    endtask

    task automatic test_single();
        apply_reset();
        alu_ready = 1'b1;
        send_ports(4'b0001, 4'd1, 32'h30, 32'h20, 2'd1);
        tests_run++;
        if (a_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early: alu_valid got %b expected 0", a_valid);
        end
        @(negedge c_clk);
        tests_run++;
        if ({a_valid, a_cmd, a_op1, a_op2, a_port, a_tag} !== {1'b1, 4'd1, 32'h30, 32'h20, 2'd0, 2'd1}) begin
            tests_failed++;
            $display("FAIL single_issue: got v=%b cmd=%h op1=%h op2=%h port=%0d tag=%0d expected v=1 cmd=1 op1=30 op2=20 port=0 tag=1",
                     a_valid, a_cmd, a_op1, a_op2, a_port, a_tag);
        end
        @(negedge c_clk);
        tests_run++;
        if (a_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after_hs: alu_valid got %b expected 0", a_valid);
        end
        alu_resp_valid = 1'b1;
        alu_resp       = 2'd1;
        alu_resp_data  = 32'h50;
        alu_resp_port  = 2'd0;
        alu_resp_tag   = 2'd1;
        @(negedge c_clk);
        alu_resp_valid = 1'b0;
        tests_run++;
        if ({a_out_resp, a_out_data, a_out_tag} !== {8'h01, 128'h50, 8'h01}) begin
            tests_failed++;
            $display("FAIL single_resp: got resp=%h data=%h tag=%h expected resp=01 data=50 tag=01", a_out_resp, a_out_data, a_out_tag);
        end
        @(negedge c_clk);
        tests_run++;
        if ({a_out_resp, a_out_data, a_out_tag} !== '0) begin
            tests_failed++;
            $display("FAIL single_resp_clear: got resp=%h data=%h tag=%h expected 0", a_out_resp, a_out_data, a_out_tag);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]   exp_resp;
        logic [127:0] exp_data;
        logic [7:0]   exp_tag;
        logic [1:0]   rv;
        apply_reset();
        alu_ready = 1'b1;
        send_ports(4'b1111, 4'd1, 32'h100, 32'h200, 2'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge c_clk);
            tests_run++;
            if ({a_valid, a_port, a_op1, a_op2} !== {1'b1, 2'(k), 32'h100 + 32'(k), 32'h200 + 32'(k)}) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got v=%b port=%0d op1=%h op2=%h expected v=1 port=%0d op1=%h",
                         k, a_valid, a_port, a_op1, a_op2, k, 32'h100 + 32'(k));
            end
        end
        @(negedge c_clk);
        alu_ready = 1'b0;
        // Four back-to-back responses to port 1 retire all outstanding commands.
        for (int k = 0; k < 4; k++) begin
            rv = (k == 3) ? 2'd2 : 2'd1;
            alu_resp_valid = 1'b1;
            alu_resp       = rv;
            alu_resp_data  = 32'hA0 + 32'(k);
            alu_resp_port  = 2'd1;
            alu_resp_tag   = 2'(k);
            @(negedge c_clk);
            exp_resp = '0; exp_resp[3:2] = rv;
            exp_data = '0; exp_data[63:32] = 32'hA0 + 32'(k);
            exp_tag  = '0; exp_tag[3:2] = 2'(k);
            tests_run++;
            if ({a_out_resp, a_out_data, a_out_tag} !== {exp_resp, exp_data, exp_tag}) begin
                tests_failed++;
                $display("FAIL b2b_resp%0d: got resp=%h data=%h tag=%h expected resp=%h data=%h tag=%h",
                         k, a_out_resp, a_out_data, a_out_tag, exp_resp, exp_data, exp_tag);
            end
        end
        alu_resp_valid = 1'b0;
        @(negedge c_clk);
        tests_run++;
        if (a_out_resp !== 8'h00) begin
            tests_failed++;
            $display("FAIL b2b_clear: out_resp got %h expected 00", a_out_resp);
        end
        send_ports(4'b1001, 4'd1, 32'h300, 32'h400, 2'd0);
        @(negedge c_clk);
        tests_run++;
        if ({a_valid, a_port, a_op1} !== {1'b1, 2'd0, 32'h300}) begin
            tests_failed++;
            $display("FAIL rr_wrap_first: got v=%b port=%0d op1=%h expected v=1 port=0 op1=300", a_valid, a_port, a_op1);
        end
        alu_ready = 1'b1;
        @(negedge c_clk);
        alu_ready = 1'b0;
        tests_run++;
        if ({a_valid, a_port, a_op1} !== {1'b1, 2'd3, 32'h303}) begin
            tests_failed++;
            $display("FAIL rr_wrap_second: got v=%b port=%0d op1=%h expected v=1 port=3 op1=303", a_valid, a_port, a_op1);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        send_ports(4'b0110, 4'd5, 32'h10, 32'h20, 2'd2);
        for (int k = 0; k < 6; k++) begin
            @(negedge c_clk);
            tests_run++;
            if ({a_valid, a_cmd, a_op1, a_op2, a_port, a_tag} !== {1'b1, 4'd5, 32'h11, 32'h21, 2'd1, 2'd2}) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got v=%b cmd=%h op1=%h op2=%h port=%0d tag=%0d expected v=1 cmd=5 op1=11 op2=21 port=1 tag=2",
                         k, a_valid, a_cmd, a_op1, a_op2, a_port, a_tag);
            end
        end
        alu_ready = 1'b1;
        @(negedge c_clk);
        tests_run++;
        if ({a_valid, a_port, a_op1, a_op2} !== {1'b1, 2'd2, 32'h12, 32'h22}) begin
            tests_failed++;
            $display("FAIL stall_next: got v=%b port=%0d op1=%h op2=%h expected v=1 port=2 op1=12 op2=22", a_valid, a_port, a_op1, a_op2);
        end
        @(negedge c_clk);
        alu_ready = 1'b0;
        tests_run++;
        if (a_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_drained: alu_valid got %b expected 0", a_valid);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        send_ports(4'b0100, 4'd1, 32'h1000, 32'h2000, 2'd0);
        send_ports(4'b0100, 4'd2, 32'h1100, 32'h2100, 2'd1);
        send_ports(4'b0100, 4'd3, 32'h1200, 32'h2200, 2'd2);
        tests_run++;
        if ({b_ovf, b_valid, b_op1} !== {4'b0000, 1'b1, 32'h1002}) begin
            tests_failed++;
            $display("FAIL ovf_before: got ovf=%b v=%b op1=%h expected ovf=0000 v=1 op1=1002", b_ovf, b_valid, b_op1);
        end
        send_ports(4'b0100, 4'd4, 32'h1300, 32'h2300, 2'd3);
        tests_run++;
        if (b_ovf !== 4'b0100) begin
            tests_failed++;
            $display("FAIL ovf_set: got %b expected 0100", b_ovf);
        end
        tests_run++;
        if (a_ovf !== 4'b0000) begin
            tests_failed++;
            $display("FAIL ovf_deep_fifo: got %b expected 0000", a_ovf);
        end
        repeat (3) @(negedge c_clk);
        tests_run++;
        if (b_ovf !== 4'b0100) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %b expected 0100", b_ovf);
        end
        alu_ready = 1'b1;
        @(negedge c_clk);
        alu_ready = 1'b0;
        tests_run++;
        if ({b_valid, b_cmd, b_op1, b_ovf} !== {1'b1, 4'd2, 32'h1102, 4'b0100}) begin
            tests_failed++;
            $display("FAIL ovf_queued: got v=%b cmd=%h op1=%h ovf=%b expected v=1 cmd=2 op1=1102 ovf=0100", b_valid, b_cmd, b_op1, b_ovf);
        end
    endtask

    task automatic test_reset_midcmd();
        req_cmd_in[7:4]   = 4'd3;
        req_data_in[63:32] = 32'h77;
        req_tag_in[3:2]   = 2'd3;
        @(negedge c_clk);
        reset = 1'b0;
        clear_inputs();
        #1;
        tests_run++;
        if ({a_valid, a_cmd, a_op1, a_op2, a_port, a_tag, a_out_resp, a_ovf} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_alu: got v=%b cmd=%h op1=%h resp=%h ovf=%b expected all 0", a_valid, a_cmd, a_op1, a_out_resp, a_ovf);
        end
        tests_run++;
        if ({b_valid, b_ovf} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_small: got v=%b ovf=%b expected 0", b_valid, b_ovf);
        end
        @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
        alu_ready = 1'b1;
        send_ports(4'b0010, 4'd6, 32'h1233, 32'h5677, 2'd2);
        @(negedge c_clk);
        alu_ready = 1'b0;
        tests_run++;
        if ({a_valid, a_cmd, a_op1, a_op2, a_port, a_tag} !== {1'b1, 4'd6, 32'h1234, 32'h5678, 2'd1, 2'd2}) begin
            tests_failed++;
            $display("FAIL midreset_recover: got v=%b cmd=%h op1=%h op2=%h port=%0d tag=%0d expected v=1 cmd=6 op1=1234 op2=5678 port=1 tag=2",
                     a_valid, a_cmd, a_op1, a_op2, a_port, a_tag);
        end
    endtask

    task automatic test_outstanding();
        apply_reset();
        alu_ready = 1'b1;
        send_ports(4'b0111, 4'd2, 32'h500, 32'h600, 2'd1);
        @(negedge c_clk);
        tests_run++;
        if ({b_valid, b_port, b_op1} !== {1'b1, 2'd0, 32'h500}) begin
            tests_failed++;
            $display("FAIL limit_first: got v=%b port=%0d op1=%h expected v=1 port=0 op1=500", b_valid, b_port, b_op1);
        end
        @(negedge c_clk);
        tests_run++;
        if ({b_valid, b_port, b_op1} !== {1'b1, 2'd1, 32'h501}) begin
            tests_failed++;
            $display("FAIL limit_second: got v=%b port=%0d op1=%h expected v=1 port=1 op1=501", b_valid, b_port, b_op1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge c_clk);
            tests_run++;
            if (b_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL limit_blocked%0d: alu_valid got %b expected 0", k, b_valid);
            end
        end
        alu_resp_valid = 1'b1;
        alu_resp       = 2'd1;
        alu_resp_data  = 32'h99;
        alu_resp_port  = 2'd0;
        alu_resp_tag   = 2'd1;
        @(negedge c_clk);
        alu_resp_valid = 1'b0;
        tests_run++;
        if ({b_valid, b_port, b_op1, b_op2} !== {1'b1, 2'd2, 32'h502, 32'h602}) begin
            tests_failed++;
            $display("FAIL limit_release: got v=%b port=%0d op1=%h op2=%h expected v=1 port=2 op1=502 op2=602", b_valid, b_port, b_op1, b_op2);
        end
        alu_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        alu_ready = 1'b0;
        clear_inputs();
        @(negedge c_clk);
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_overflow();
        test_reset_midcmd();
        test_outstanding();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
